// File: rtl/hier_icache_flush_sequencer_pkg.sv
// Shared types for the hierarchical I-cache maintenance sequencer:
// command opcodes, FSM states and the opcode width.
package hier_icache_seq_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ENABLE    = 3'd0,
    OP_DISABLE   = 3'd1,
    OP_FLUSH_ALL = 3'd2,
    OP_SEL_FLUSH = 3'd3,
    OP_FLUSH_L1  = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_L1_PHASE,
    ST_L2_PHASE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/hier_icache_flush_sequencer_if.sv
// Command and cache-control bus of the I-cache maintenance sequencer.
// The master modport is the sequencer's view; slave is the environment side
// (control register block plus the L1/L2 cache controllers).
interface hier_icache_flush_sequencer_if #(
  parameter int NB_CORES       = 9,
  parameter int NB_CACHE_BANKS = 4
) ();
  import hier_icache_seq_pkg::*;

  logic                      cmd_valid_i;
  logic                      cmd_ready_o;
  logic [OP_W-1:0]           cmd_op_i;
  logic [NB_CORES-1:0]       cmd_core_mask_i;
  logic [31:0]               cmd_addr_i;
  logic                      busy_o;
  logic                      done_o;
  logic                      err_o;

  logic [NB_CORES-1:0]       l1_bypass_req_o;
  logic [NB_CORES-1:0]       l1_flush_req_o;
  logic [NB_CORES-1:0]       l1_sel_flush_req_o;
  logic [31:0]               l1_sel_flush_addr_o;
  logic [NB_CORES-1:0]       l1_bypass_ack_i;
  logic [NB_CORES-1:0]       l1_flush_ack_i;
  logic [NB_CORES-1:0]       l1_sel_flush_ack_i;

  logic [NB_CACHE_BANKS-1:0] l2_enable_req_o;
  logic [NB_CACHE_BANKS-1:0] l2_disable_req_o;
  logic [NB_CACHE_BANKS-1:0] l2_flush_req_o;
  logic [NB_CACHE_BANKS-1:0] l2_sel_flush_req_o;
  logic [31:0]               l2_sel_flush_addr_o;
  logic [NB_CACHE_BANKS-1:0] l2_enable_ack_i;
  logic [NB_CACHE_BANKS-1:0] l2_disable_ack_i;
  logic [NB_CACHE_BANKS-1:0] l2_flush_ack_i;
  logic [NB_CACHE_BANKS-1:0] l2_sel_flush_ack_i;

  modport master (
    input  cmd_valid_i, cmd_op_i, cmd_core_mask_i, cmd_addr_i,
    input  l1_bypass_ack_i, l1_flush_ack_i, l1_sel_flush_ack_i,
    input  l2_enable_ack_i, l2_disable_ack_i, l2_flush_ack_i, l2_sel_flush_ack_i,
    output cmd_ready_o, busy_o, done_o, err_o,
    output l1_bypass_req_o, l1_flush_req_o, l1_sel_flush_req_o, l1_sel_flush_addr_o,
    output l2_enable_req_o, l2_disable_req_o, l2_flush_req_o, l2_sel_flush_req_o,
    output l2_sel_flush_addr_o
  );

  modport slave (
    output cmd_valid_i, cmd_op_i, cmd_core_mask_i, cmd_addr_i,
    output l1_bypass_ack_i, l1_flush_ack_i, l1_sel_flush_ack_i,
    output l2_enable_ack_i, l2_disable_ack_i, l2_flush_ack_i, l2_sel_flush_ack_i,
    input  cmd_ready_o, busy_o, done_o, err_o,
    input  l1_bypass_req_o, l1_flush_req_o, l1_sel_flush_req_o, l1_sel_flush_addr_o,
    input  l2_enable_req_o, l2_disable_req_o, l2_flush_req_o, l2_sel_flush_req_o,
    input  l2_sel_flush_addr_o
  );
endinterface

// File: rtl/hier_icache_flush_sequencer_ack_tracker.sv
// Pending-acknowledge tracker for one cache level. A load replaces the
// pending vector; otherwise every acked pending line clears at the next edge.
// all_clear_next_o flags that nothing will remain pending after this edge.
module hier_icache_ack_tracker #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic [WIDTH-1:0] ack_i,
  output logic [WIDTH-1:0] pending_o,
  output logic             all_clear_next_o
);
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] remaining;

  assign remaining        = pending_q & ~ack_i;
  assign all_clear_next_o = ~|remaining;
  assign pending_o        = pending_q;

  // Next pending vector: load wins over ack clearing.
  always_comb begin
    // NOTE: default assignment first so every path drives pending_d and no latch is inferred.
    pending_d = remaining;
    if (load_i) pending_d = load_value_i;
  end

  // Pending register with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignment so all flops update from pre-edge values.
    if (rst_i) pending_q <= '0;
    else       pending_q <= pending_d;
  end
endmodule

// File: rtl/hier_icache_flush_sequencer.sv
// Hierarchical I-cache maintenance sequencer: accepts one command, runs the
// L1 phase (per-core) then the L2 phase (per-bank), tracks every ack and
// pulses done_o. Optional per-phase watchdog: HIER_ICACHE_SEQ_TIMEOUT_EN.
module hier_icache_flush_sequencer
  import hier_icache_seq_pkg::*;
#(
  parameter int NB_CORES       = 9,
  parameter int NB_CACHE_BANKS = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                           clk_i,
  input logic                           rst_i,
  hier_icache_flush_sequencer_if.master bus
);
  state_e                    state_q, state_d;
  op_e                       op_q, op_d;
  logic [31:0]               addr_q, addr_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;

  logic                      l1_load, l1_all_clear;
  logic [NB_CORES-1:0]       l1_load_value, l1_ack, l1_pending;
  logic                      l2_load, l2_all_clear;
  logic [NB_CACHE_BANKS-1:0] l2_load_value, l2_ack, l2_pending;
  logic                      tmo_hit;

`ifdef HIER_ICACHE_SEQ_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Phase cycle counter: restarts on every state change, counts while a phase holds.
  always_comb begin
    tmo_cnt_d = '0;
    if (state_d == state_q && (state_q == ST_L1_PHASE || state_q == ST_L2_PHASE))
      tmo_cnt_d = tmo_cnt_q + 1'b1;
  end

  // Watchdog counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) tmo_cnt_q <= '0;
    else       tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Route only the ack type matching the latched opcode into each tracker.
  always_comb begin
    l1_ack = '0;
    l2_ack = '0;
    case (op_q)
      OP_ENABLE:              l2_ack = bus.l2_enable_ack_i;
      OP_DISABLE:   begin     l1_ack = bus.l1_bypass_ack_i;    l2_ack = bus.l2_disable_ack_i;   end
      OP_FLUSH_ALL: begin     l1_ack = bus.l1_flush_ack_i;     l2_ack = bus.l2_flush_ack_i;     end
      OP_SEL_FLUSH: begin     l1_ack = bus.l1_sel_flush_ack_i; l2_ack = bus.l2_sel_flush_ack_i; end
      OP_FLUSH_L1:            l1_ack = bus.l1_flush_ack_i;
      default: ;
    endcase
  end

  // Next-state, tracker loads and registered status.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    err_d         = 1'b0;
    l1_load       = 1'b0;
    l1_load_value = bus.cmd_core_mask_i;
    l2_load       = 1'b0;
    l2_load_value = '1;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid_i) begin
          op_d   = op_e'(bus.cmd_op_i);
          addr_d = bus.cmd_addr_i;
          if (bus.cmd_op_i > OP_FLUSH_L1) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else if (op_e'(bus.cmd_op_i) == OP_ENABLE) begin
            state_d = ST_L2_PHASE;
            l2_load = 1'b1;
          end else begin
            state_d = ST_L1_PHASE;
            l1_load = 1'b1;
          end
        end
      end
      ST_L1_PHASE: begin
        if (l1_all_clear) begin
          if (op_q == OP_FLUSH_L1) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_L2_PHASE;
            l2_load = 1'b1;
          end
        end else if (tmo_hit) begin
          state_d       = ST_DONE;
          err_d         = 1'b1;
          l1_load       = 1'b1;
          l1_load_value = '0;
        end
      end
      ST_L2_PHASE: begin
        if (l2_all_clear) begin
          state_d = ST_DONE;
        end else if (tmo_hit) begin
          state_d       = ST_DONE;
          err_d         = 1'b1;
          l2_load       = 1'b1;
          l2_load_value = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    done_d = (state_d == ST_DONE);
  end

  // FSM and status registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ENABLE;
      addr_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  hier_icache_ack_tracker #(.WIDTH(NB_CORES)) u_l1_tracker (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .load_i          (l1_load),
    .load_value_i    (l1_load_value),
    .ack_i           (l1_ack),
    .pending_o       (l1_pending),
    .all_clear_next_o(l1_all_clear)
  );

  hier_icache_ack_tracker #(.WIDTH(NB_CACHE_BANKS)) u_l2_tracker (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .load_i          (l2_load),
    .load_value_i    (l2_load_value),
    .ack_i           (l2_ack),
    .pending_o       (l2_pending),
    .all_clear_next_o(l2_all_clear)
  );

  // Pending vectors are only non-zero inside their own phase, so each req
  // type is simply the pending vector gated by the latched opcode.
  assign bus.l1_bypass_req_o    = l1_pending & {NB_CORES{op_q == OP_DISABLE}};
  assign bus.l1_flush_req_o     = l1_pending & {NB_CORES{op_q == OP_FLUSH_ALL || op_q == OP_FLUSH_L1}};
  assign bus.l1_sel_flush_req_o = l1_pending & {NB_CORES{op_q == OP_SEL_FLUSH}};
  assign bus.l2_enable_req_o    = l2_pending & {NB_CACHE_BANKS{op_q == OP_ENABLE}};
  assign bus.l2_disable_req_o   = l2_pending & {NB_CACHE_BANKS{op_q == OP_DISABLE}};
  assign bus.l2_flush_req_o     = l2_pending & {NB_CACHE_BANKS{op_q == OP_FLUSH_ALL}};
  assign bus.l2_sel_flush_req_o = l2_pending & {NB_CACHE_BANKS{op_q == OP_SEL_FLUSH}};

  assign bus.l1_sel_flush_addr_o = addr_q;
  assign bus.l2_sel_flush_addr_o = addr_q;
  assign bus.cmd_ready_o         = (state_q == ST_IDLE) && !rst_i;
  assign bus.busy_o              = (state_q != ST_IDLE);
  assign bus.done_o              = done_q;
  assign bus.err_o               = err_q;
endmodule

// File: tb/tb_hier_icache_flush_sequencer.sv
// Self-checking bench for hier_icache_flush_sequencer: directed scenarios with
// literal expectations plus randomized traffic against a behavioural model.
// Build with HIER_ICACHE_SEQ_TIMEOUT_EN to exercise the watchdog.
module tb_hier_icache_flush_sequencer;
  localparam int NC  = 9;
  localparam int NB  = 4;
  localparam int TMO = 16;
`ifdef HIER_ICACHE_SEQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  hier_icache_flush_sequencer_if #(.NB_CORES(NC), .NB_CACHE_BANKS(NB)) bus ();

  hier_icache_flush_sequencer #(
    .NB_CORES(NC), .NB_CACHE_BANKS(NB), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 L1 phase, 2 L2 phase, 3 done
  int          m_phase = 0;
  int          m_op    = 0;
  logic [NC-1:0] m_l1p = '0;
  logic [NB-1:0] m_l2p = '0;
  logic [31:0] m_addr  = '0;
  bit          m_err   = 1'b0;
  int          m_cnt   = 0;

  function automatic logic [NC-1:0] l1_ack_of(input int op);
    case (op)
      1:       return bus.l1_bypass_ack_i;
      2, 4:    return bus.l1_flush_ack_i;
      3:       return bus.l1_sel_flush_ack_i;
      default: return '0;
    endcase
  endfunction

  function automatic logic [NB-1:0] l2_ack_of(input int op);
    case (op)
      0:       return bus.l2_enable_ack_i;
      1:       return bus.l2_disable_ack_i;
      2:       return bus.l2_flush_ack_i;
      3:       return bus.l2_sel_flush_ack_i;
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    int n_phase, n_op, n_cnt;
    logic [NC-1:0] n_l1p, rem1;
    logic [NB-1:0] n_l2p, rem2;
    logic [31:0] n_addr;
    bit n_err;
    n_phase = m_phase; n_op = m_op; n_cnt = m_cnt;
    n_l1p = m_l1p; n_l2p = m_l2p; n_addr = m_addr; n_err = m_err;
    rem1 = m_l1p & ~l1_ack_of(m_op);
    rem2 = m_l2p & ~l2_ack_of(m_op);
    if (rst_i) begin
      n_phase = 0; n_l1p = '0; n_l2p = '0; n_addr = '0; n_err = 1'b0; n_cnt = 0;
    end else begin
      case (m_phase)
        0: if (bus.cmd_valid_i) begin
          n_op = int'(bus.cmd_op_i); n_addr = bus.cmd_addr_i; n_err = 1'b0; n_cnt = 0;
          if (n_op > 4)       begin n_phase = 3; n_err = 1'b1; end
          else if (n_op == 0) begin n_phase = 2; n_l2p = '1; end
          else                begin n_phase = 1; n_l1p = bus.cmd_core_mask_i; end
        end
        1: if (rem1 == '0) begin
          n_l1p = '0; n_cnt = 0;
          if (m_op == 4) n_phase = 3;
          else begin n_phase = 2; n_l2p = '1; end
        end else if (TMO_EN && m_cnt == TMO - 1) begin
          n_l1p = '0; n_phase = 3; n_err = 1'b1;
        end else begin
          n_l1p = rem1; n_cnt = m_cnt + 1;
        end
        2: if (rem2 == '0) begin
          n_l2p = '0; n_phase = 3;
        end else if (TMO_EN && m_cnt == TMO - 1) begin
          n_l2p = '0; n_phase = 3; n_err = 1'b1;
        end else begin
          n_l2p = rem2; n_cnt = m_cnt + 1;
        end
        default: n_phase = 0;
      endcase
    end
    m_phase <= n_phase; m_op <= n_op; m_cnt <= n_cnt;
    m_l1p <= n_l1p; m_l2p <= n_l2p; m_addr <= n_addr; m_err <= n_err;
  end

  // One compare process: all outputs against the model, every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_ready", bus.cmd_ready_o, (m_phase == 0) && !rst_i);
      check("m_busy", bus.busy_o, m_phase != 0);
      check("m_done", bus.done_o, m_phase == 3);
      check("m_err", bus.err_o, (m_phase == 3) && m_err);
      check("m_l1_byp", bus.l1_bypass_req_o, (m_phase == 1 && m_op == 1) ? m_l1p : '0);
      check("m_l1_fl", bus.l1_flush_req_o, (m_phase == 1 && (m_op == 2 || m_op == 4)) ? m_l1p : '0);
      check("m_l1_sel", bus.l1_sel_flush_req_o, (m_phase == 1 && m_op == 3) ? m_l1p : '0);
      check("m_l2_en", bus.l2_enable_req_o, (m_phase == 2 && m_op == 0) ? m_l2p : '0);
      check("m_l2_dis", bus.l2_disable_req_o, (m_phase == 2 && m_op == 1) ? m_l2p : '0);
      check("m_l2_fl", bus.l2_flush_req_o, (m_phase == 2 && m_op == 2) ? m_l2p : '0);
      check("m_l2_sel", bus.l2_sel_flush_req_o, (m_phase == 2 && m_op == 3) ? m_l2p : '0);
      check("m_l1_addr", bus.l1_sel_flush_addr_o, m_addr);
      check("m_l2_addr", bus.l2_sel_flush_addr_o, m_addr);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_acks();
    bus.l1_bypass_ack_i = '0; bus.l1_flush_ack_i = '0; bus.l1_sel_flush_ack_i = '0;
    bus.l2_enable_ack_i = '0; bus.l2_disable_ack_i = '0;
    bus.l2_flush_ack_i = '0;  bus.l2_sel_flush_ack_i = '0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [NC-1:0] mask, input logic [31:0] addr);
    bus.cmd_valid_i = 1'b1; bus.cmd_op_i = op;
    bus.cmd_core_mask_i = mask; bus.cmd_addr_i = addr;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_i = 1'b1;
    bus.cmd_valid_i = 1'b0; bus.cmd_op_i = '0; bus.cmd_core_mask_i = '0; bus.cmd_addr_i = '0;
    clear_acks();
    tick();
    chk_en = 1'b1;
    // Reset values while rst_i is held.
    @(negedge clk);
    check("rst_ready", bus.cmd_ready_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_l1_req", bus.l1_flush_req_o, 0);
    check("rst_addr", bus.l1_sel_flush_addr_o, 0);
    tick();
    rst_i = 1'b0;
    @(negedge clk);
    check("post_rst_ready", bus.cmd_ready_o, 1);

    // FLUSH_ALL, full mask, acks returned the same cycle.
    issue(3'd2, 9'h1FF, 32'h0);
    tick();  // t1
    bus.cmd_valid_i = 1'b0;
    bus.l1_flush_ack_i = '1; bus.l2_flush_ack_i = '1;
    @(negedge clk);
    check("fa_t1_l1", bus.l1_flush_req_o, 9'h1FF);
    check("fa_t1_l2", bus.l2_flush_req_o, 4'h0);
    tick();  // t2
    @(negedge clk);
    check("fa_t2_l1", bus.l1_flush_req_o, 9'h000);
    check("fa_t2_l2", bus.l2_flush_req_o, 4'hF);
    tick();  // t3
    clear_acks();
    @(negedge clk);
    check("fa_t3_done", bus.done_o, 1);
    check("fa_t3_err", bus.err_o, 0);
    check("fa_t3_ready", bus.cmd_ready_o, 0);
    tick();  // t4
    @(negedge clk);
    check("fa_t4_ready", bus.cmd_ready_o, 1);

    // SEL_FLUSH with staggered L1 acks.
    issue(3'd3, 9'h005, 32'h1C00_8040);
    tick();
    bus.cmd_valid_i = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      bus.l1_sel_flush_ack_i = (t == 3) ? 9'h001 : (t == 6) ? 9'h004 : 9'h000;
      bus.l2_sel_flush_ack_i = (t == 7) ? 4'hF : 4'h0;
      @(negedge clk);
      check("sf_l1", bus.l1_sel_flush_req_o, (t <= 3) ? 9'h005 : (t <= 6) ? 9'h004 : 9'h000);
      check("sf_l2", bus.l2_sel_flush_req_o, (t == 7) ? 4'hF : 4'h0);
      check("sf_done", bus.done_o, t == 8);
      check("sf_addr1", bus.l1_sel_flush_addr_o, 32'h1C00_8040);
      check("sf_addr2", bus.l2_sel_flush_addr_o, 32'h1C00_8040);
      tick();
    end
    clear_acks();

    // DISABLE with empty mask, spurious bypass ack in t1.
    issue(3'd1, 9'h000, 32'h0);
    tick();  // t1
    bus.cmd_valid_i = 1'b0;
    bus.l1_bypass_ack_i = '1;
    @(negedge clk);
    check("dis_t1_l1", bus.l1_bypass_req_o, 0);
    check("dis_t1_l2", bus.l2_disable_req_o, 0);
    check("dis_t1_busy", bus.busy_o, 1);
    tick();  // t2
    bus.l1_bypass_ack_i = '0; bus.l2_disable_ack_i = '1;
    @(negedge clk);
    check("dis_t2_l2", bus.l2_disable_req_o, 4'hF);
    tick();  // t3
    clear_acks();
    @(negedge clk);
    check("dis_t3_done", bus.done_o, 1);
    tick();

    // Illegal opcode 6.
    issue(3'd6, 9'h1FF, 32'hDEAD_BEEF);
    tick();  // t1
    bus.cmd_valid_i = 1'b0;
    @(negedge clk);
    check("ill_t1_done", bus.done_o, 1);
    check("ill_t1_err", bus.err_o, 1);
    check("ill_t1_l1", bus.l1_flush_req_o | bus.l1_bypass_req_o | bus.l1_sel_flush_req_o, 0);
    tick();  // t2
    @(negedge clk);
    check("ill_t2_ready", bus.cmd_ready_o, 1);
    check("ill_t2_err", bus.err_o, 0);

    // ENABLE where bank 3 never acks.
    issue(3'd0, 9'h000, 32'h0);
    tick();  // t1
    bus.cmd_valid_i = 1'b0;
    bus.l2_enable_ack_i = 4'h7;
`ifdef HIER_ICACHE_SEQ_TIMEOUT_EN
    for (int t = 1; t <= 17; t++) begin
      @(negedge clk);
      check("tmo_req", bus.l2_enable_req_o, (t == 1) ? 4'hF : (t <= 16) ? 4'h8 : 4'h0);
      check("tmo_done", bus.done_o, t == 17);
      check("tmo_err", bus.err_o, t == 17);
      tick();
      bus.l2_enable_ack_i = '0;
    end
`else
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      check("hang_busy", bus.busy_o, 1);
      check("hang_req", bus.l2_enable_req_o, (t == 1) ? 4'hF : 4'h8);
      tick();
      bus.l2_enable_ack_i = '0;
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    @(negedge clk);
    check("hang_rst_req", bus.l2_enable_req_o, 0);
    check("hang_rst_done", bus.done_o, 0);
`endif

    // Reset in L2 phase with banks 2 and 3 pending, then a fresh ENABLE.
    issue(3'd2, 9'h003, 32'h0000_1234);
    tick();  // t1
    bus.cmd_valid_i = 1'b0;
    bus.l1_flush_ack_i = 9'h003;
    tick();  // t2
    bus.l1_flush_ack_i = '0; bus.l2_flush_ack_i = 4'h3;
    @(negedge clk);
    check("rs_t2_l2", bus.l2_flush_req_o, 4'hF);
    tick();  // t3
    bus.l2_flush_ack_i = '0;
    rst_i = 1'b1;
    @(negedge clk);
    check("rs_t3_l2", bus.l2_flush_req_o, 4'hC);
    tick();  // t4
    rst_i = 1'b0;
    @(negedge clk);
    check("rs_t4_l2", bus.l2_flush_req_o, 0);
    check("rs_t4_done", bus.done_o, 0);
    check("rs_t4_ready", bus.cmd_ready_o, 1);
    issue(3'd0, 9'h000, 32'h0);
    tick();  // t5
    bus.cmd_valid_i = 1'b0;
    bus.l2_enable_ack_i = 4'hF;
    @(negedge clk);
    check("rs_en_req", bus.l2_enable_req_o, 4'hF);
    tick();  // t6
    clear_acks();
    @(negedge clk);
    check("rs_en_done", bus.done_o, 1);
    check("rs_en_err", bus.err_o, 0);
    tick();

    // Randomized traffic, checked by the model every cycle.
    for (int c = 0; c < 1500; c++) begin
      bus.cmd_valid_i = ($urandom_range(0, 3) == 0);
      bus.cmd_op_i = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      bus.cmd_core_mask_i = ($urandom_range(0, 7) == 0) ? '0 : NC'($urandom);
      bus.cmd_addr_i = $urandom;
      bus.l1_bypass_ack_i    = NC'($urandom & $urandom);
      bus.l1_flush_ack_i     = NC'($urandom & $urandom);
      bus.l1_sel_flush_ack_i = NC'($urandom & $urandom);
      bus.l2_enable_ack_i    = NB'($urandom & $urandom);
      bus.l2_disable_ack_i   = NB'($urandom & $urandom);
      bus.l2_flush_ack_i     = NB'($urandom & $urandom);
      bus.l2_sel_flush_ack_i = NB'($urandom & $urandom);
      rst_i = ($urandom_range(0, 199) == 0);
      tick();
    end
    bus.cmd_valid_i = 1'b0;
    clear_acks();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tick();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
